// File: rtl/isa_pkg.sv
// Shared constants and head classification for the ISA tx scheduler.
// Word format is {addr[31:0], data[31:0]}, with the timestamp in data[23:0].
package isa_pkg;

  localparam int TS_W = 24;

  localparam logic [31:0] ADDR_TRIG = 32'h4000_1000;
  localparam logic [31:0] ADDR_HALT = 32'h4000_1FFC;
  localparam logic [19:0] OP_PAGE   = 20'h40004;

  typedef enum logic [1:0] {
    TRIG,
    HALT,
    OP,
    OTHER
  } head_class_e;

  function automatic head_class_e classify(input logic [31:0] addr);
    if (addr == ADDR_TRIG)
      return TRIG;
    else if (addr == ADDR_HALT)
      return HALT;
    else if (addr[31:12] == OP_PAGE)
      return OP;
    else
      return OTHER;
  endfunction

endpackage

// File: rtl/isa_tx_scheduler_if.sv
// Decoder tx port: 64-bit word with valid (I_tx_en) / ready (O_tx_ready) handshake.
interface isa_tx_scheduler_if;

  logic [63:0] I_tx_data;
  logic        I_tx_en;
  logic        O_tx_ready;

  modport master (
    output I_tx_data,
    output I_tx_en,
    input  O_tx_ready
  );

  modport slave (
    input  I_tx_data,
    input  I_tx_en,
    output O_tx_ready
  );

endinterface

// File: rtl/isa_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate counter.
module isa_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     I_clk,
  input  logic                     I_rst,
  input  logic                     I_push,
  input  logic [WIDTH-1:0]         I_wdata,
  input  logic                     I_pop,
  output logic [WIDTH-1:0]         O_head,
  output logic                     O_empty,
  output logic                     O_full,
  output logic [$clog2(DEPTH):0]   O_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign O_level = wr_ptr - rd_ptr;
  assign O_empty = (wr_ptr == rd_ptr);
  assign O_full  = (O_level == LVL_FULL);
  assign O_head  = mem[rd_ptr[AW-1:0]];

  assign do_push = I_push & ~O_full;
  assign do_pop  = I_pop & ~O_empty;

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; the pointers alone define valid contents.
  always_ff @(posedge I_clk) begin
    if (!I_rst && do_push)
      mem[wr_ptr[AW-1:0]] <= I_wdata;
  end

endmodule

// File: rtl/isa_tx_scheduler.sv
// Buffers decoder words and releases OP words as one-cycle strobes once the
// 24-bit timeline started by a TRIG word reaches the word's timestamp.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   idle     | O_running=0, timer held at 0; OP at head stalls
//   running  | timer counts up (saturating); OPs release when timer >= ts
module isa_tx_scheduler #(
  parameter int FIFO_DEPTH = 16,
  parameter int TS_W       = 24
) (
  input  logic                          I_clk,
  input  logic                          I_rst,
  isa_tx_scheduler_if.slave             tx,
  output logic                          O_op_valid,
  output logic [31:0]                   O_op_addr,
  output logic [7:0]                    O_op_code,
  output logic [TS_W-1:0]               O_op_ts,
  output logic [TS_W-1:0]               O_timer,
  output logic                          O_running,
  output logic                          O_late,
  output logic                          O_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   O_level
);

  import isa_pkg::*;

  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic            fifo_full;
  logic [63:0]     head;
  logic [31:0]     head_addr;
  logic [7:0]      head_code;
  logic [TS_W-1:0] head_ts;
  head_class_e     head_cls;
  logic            op_due;
  logic            rel_go;
  logic            timer_clear;

  assign tx.O_tx_ready = ~I_rst & ~fifo_full;
  assign push          = tx.I_tx_en & tx.O_tx_ready;

  isa_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .I_clk   (I_clk),
    .I_rst   (I_rst),
    .I_push  (push),
    .I_wdata (tx.I_tx_data),
    .I_pop   (pop),
    .O_head  (head),
    .O_empty (fifo_empty),
    .O_full  (fifo_full),
    .O_level (O_level)
  );

  assign head_addr = head[63:32];
  assign head_code = head[31:24];
  assign head_ts   = head[TS_W-1:0];
  assign head_cls  = classify(head_addr);
  assign op_due    = O_running & (O_timer >= head_ts);

  always_comb begin
    pop         = 1'b0;
    rel_go      = 1'b0;
    timer_clear = 1'b0;
    if (!fifo_empty) begin
      case (head_cls)
        TRIG, HALT: begin
          pop         = 1'b1;
          timer_clear = 1'b1;
        end
        OP: begin
          pop    = op_due;
          rel_go = op_due;
        end
        default: pop = 1'b1;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_op_valid <= 1'b0;
      O_op_addr  <= '0;
      O_op_code  <= '0;
      O_op_ts    <= '0;
      O_timer    <= '0;
      O_running  <= 1'b0;
      O_late     <= 1'b0;
      O_overflow <= 1'b0;
    end else begin
      O_op_valid <= rel_go;
      if (rel_go) begin
        O_op_addr <= head_addr;
        O_op_code <= head_code;
        O_op_ts   <= head_ts;
        if (O_timer > head_ts)
          O_late <= 1'b1;
      end

      if (tx.I_tx_en && !tx.O_tx_ready)
        O_overflow <= 1'b1;

      // A clear takes precedence over the increment in the same cycle.
      if (timer_clear) begin
        O_timer   <= '0;
        O_running <= (head_cls == TRIG);
      end else if (O_running && (O_timer != '1)) begin
        O_timer <= O_timer + TS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_isa_tx_scheduler.sv
// Directed bench for isa_tx_scheduler with hand-computed expectations.
module tb_isa_tx_scheduler;

  localparam logic [31:0] A_TRIG  = 32'h4000_1000;
  localparam logic [31:0] A_HALT  = 32'h4000_1FFC;
  localparam logic [31:0] A_OTHER = 32'h4000_1004;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        O_op_valid;
  logic [31:0] O_op_addr;
  logic [7:0]  O_op_code;
  logic [23:0] O_op_ts;
  logic [23:0] O_timer;
  logic        O_running;
  logic        O_late;
  logic        O_overflow;
  logic [4:0]  O_level;

  int n_checks = 0;
  int n_fail   = 0;

  isa_tx_scheduler_if tx_if ();

  isa_tx_scheduler #(
    .FIFO_DEPTH (16),
    .TS_W       (24)
  ) dut (
    .I_clk      (I_clk),
    .I_rst      (I_rst),
    .tx         (tx_if),
    .O_op_valid (O_op_valid),
    .O_op_addr  (O_op_addr),
    .O_op_code  (O_op_code),
    .O_op_ts    (O_op_ts),
    .O_timer    (O_timer),
    .O_running  (O_running),
    .O_late     (O_late),
    .O_overflow (O_overflow),
    .O_level    (O_level)
  );

  always #5 I_clk = ~I_clk;

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  function automatic logic [63:0] op_word(input logic [11:0] off, input logic [7:0] code,
                                          input logic [23:0] ts);
    return {20'h40004, off, code, ts};
  endfunction

  task automatic push(input logic [63:0] w);
    tx_if.I_tx_data = w;
    tx_if.I_tx_en   = 1'b1;
    tick();
    tx_if.I_tx_en   = 1'b0;
  endtask

  task automatic do_reset();
    I_rst = 1'b1;
    tick();
    tick();
    I_rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    I_rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({O_op_valid, O_op_addr, O_op_code, O_op_ts, O_timer, O_running, O_late, O_overflow, O_level} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b addr=%h code=%h ts=%h timer=%h run=%b late=%b ovf=%b lvl=%0d, expected all 0",
               O_op_valid, O_op_addr, O_op_code, O_op_ts, O_timer, O_running, O_late, O_overflow, O_level);
    end
    n_checks++;
    if (tx_if.O_tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_low: got %b expected 0", tx_if.O_tx_ready);
    end
    I_rst = 1'b0;
    #1;
    n_checks++;
    if (tx_if.O_tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_high: got %b expected 1", tx_if.O_tx_ready);
    end
  endtask

  task automatic test_basic_release();
    do_reset();
    push({A_TRIG, 32'h0});
    push(op_word(12'h000, 8'hA5, 24'd5));
    n_checks++;
    if (O_timer !== 24'd0 || O_running !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_timer_start: got timer=%0d run=%b expected 0/1", O_timer, O_running);
    end
    repeat (5) tick();
    n_checks++;
    if (O_timer !== 24'd5 || O_op_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_before_release: got timer=%0d valid=%b expected 5/0", O_timer, O_op_valid);
    end
    tick();
    n_checks++;
    if (O_op_valid !== 1'b1 || O_op_code !== 8'hA5 || O_op_ts !== 24'd5 ||
        O_op_addr !== 32'h4000_4000 || O_late !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_release: got valid=%b code=%h ts=%0d addr=%h late=%b expected 1/a5/5/40004000/0",
               O_op_valid, O_op_code, O_op_ts, O_op_addr, O_late);
    end
    tick();
    n_checks++;
    if (O_op_valid !== 1'b0 || O_op_code !== 8'hA5 || O_op_ts !== 24'd5 || O_level !== 5'd0) begin
      n_fail++;
      $display("FAIL basic_hold: got valid=%b code=%h ts=%0d lvl=%0d expected 0/a5/5/0",
               O_op_valid, O_op_code, O_op_ts, O_level);
    end
  endtask

  task automatic test_late();
    do_reset();
    push({A_TRIG, 32'h0});
    repeat (20) tick();
    push(op_word(12'h008, 8'h3C, 24'd3));
    n_checks++;
    if (O_op_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL late_early_strobe: got valid=%b expected 0", O_op_valid);
    end
    tick();
    n_checks++;
    if (O_op_valid !== 1'b1 || O_op_ts !== 24'd3 || O_op_code !== 8'h3C || O_late !== 1'b1) begin
      n_fail++;
      $display("FAIL late_release: got valid=%b ts=%0d code=%h late=%b expected 1/3/3c/1",
               O_op_valid, O_op_ts, O_op_code, O_late);
    end
  endtask

  task automatic test_deadlock_overflow();
    logic seen_valid;
    logic ready_dropped_early;
    seen_valid = 1'b0;
    ready_dropped_early = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (tx_if.O_tx_ready !== 1'b1) ready_dropped_early = 1'b1;
      push(op_word(12'(i * 4), 8'(i), 24'd1));
      if (O_op_valid !== 1'b0) seen_valid = 1'b1;
    end
    n_checks++;
    if (ready_dropped_early !== 1'b0) begin
      n_fail++;
      $display("FAIL dl_ready_while_filling: got dropped=%b expected 0", ready_dropped_early);
    end
    n_checks++;
    if (O_level !== 5'd16 || tx_if.O_tx_ready !== 1'b0 || O_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL dl_full: got lvl=%0d ready=%b ovf=%b expected 16/0/0", O_level, tx_if.O_tx_ready, O_overflow);
    end
    push(op_word(12'hFFC, 8'hEE, 24'd0));
    repeat (3) begin
      tick();
      if (O_op_valid !== 1'b0) seen_valid = 1'b1;
    end
    n_checks++;
    if (O_overflow !== 1'b1 || O_level !== 5'd16 || O_running !== 1'b0) begin
      n_fail++;
      $display("FAIL dl_overflow: got ovf=%b lvl=%0d run=%b expected 1/16/0", O_overflow, O_level, O_running);
    end
    n_checks++;
    if (seen_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dl_no_release: got strobe_seen=%b expected 0", seen_valid);
    end
    do_reset();
    n_checks++;
    if (O_overflow !== 1'b0 || O_level !== 5'd0 || tx_if.O_tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL dl_reset_clear: got ovf=%b lvl=%0d ready=%b expected 0/0/1", O_overflow, O_level, tx_if.O_tx_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_code [3];
    exp_code[0] = 8'h01;
    exp_code[1] = 8'h02;
    exp_code[2] = 8'h03;
    do_reset();
    push({A_TRIG, 32'h0});
    push(op_word(12'h010, 8'h01, 24'd2));
    push(op_word(12'h020, 8'h02, 24'd2));
    push(op_word(12'h030, 8'h03, 24'd2));
    n_checks++;
    if (O_op_valid !== 1'b0 || O_timer !== 24'd2) begin
      n_fail++;
      $display("FAIL b2b_pre: got valid=%b timer=%0d expected 0/2", O_op_valid, O_timer);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (O_op_valid !== 1'b1 || O_op_code !== exp_code[i] || O_op_ts !== 24'd2) begin
        n_fail++;
        $display("FAIL b2b_release_%0d: got valid=%b code=%h ts=%0d expected 1/%h/2",
                 i, O_op_valid, O_op_code, O_op_ts, exp_code[i]);
      end
    end
    tick();
    n_checks++;
    if (O_op_valid !== 1'b0 || O_late !== 1'b1 || O_level !== 5'd0) begin
      n_fail++;
      $display("FAIL b2b_after: got valid=%b late=%b lvl=%0d expected 0/1/0", O_op_valid, O_late, O_level);
    end
    push({A_HALT, 32'h0});
    n_checks++;
    if (O_running !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_pending: got run=%b expected 1", O_running);
    end
    tick();
    n_checks++;
    if (O_running !== 1'b0 || O_timer !== 24'd0) begin
      n_fail++;
      $display("FAIL halt: got run=%b timer=%0d expected 0/0", O_running, O_timer);
    end
    tick();
    n_checks++;
    if (O_timer !== 24'd0) begin
      n_fail++;
      $display("FAIL halt_timer_frozen: got timer=%0d expected 0", O_timer);
    end
  endtask

  task automatic test_discard_and_reset();
    do_reset();
    push({A_TRIG, 32'h0});
    push({A_OTHER, 32'h1234_5678});
    push(op_word(12'h040, 8'h5A, 24'd4));
    n_checks++;
    if (O_timer !== 24'd1 || O_op_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL discard_pre: got timer=%0d valid=%b expected 1/0", O_timer, O_op_valid);
    end
    repeat (3) tick();
    n_checks++;
    if (O_timer !== 24'd4 || O_op_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL discard_at_ts: got timer=%0d valid=%b expected 4/0", O_timer, O_op_valid);
    end
    tick();
    n_checks++;
    if (O_op_valid !== 1'b1 || O_op_code !== 8'h5A || O_op_addr !== 32'h4000_4040 || O_late !== 1'b0) begin
      n_fail++;
      $display("FAIL discard_release: got valid=%b code=%h addr=%h late=%b expected 1/5a/40004040/0",
               O_op_valid, O_op_code, O_op_addr, O_late);
    end
    push(op_word(12'h044, 8'h11, 24'd0));
    tick();
    n_checks++;
    if (O_op_valid !== 1'b1 || O_op_code !== 8'h11 || O_late !== 1'b1) begin
      n_fail++;
      $display("FAIL late_set: got valid=%b code=%h late=%b expected 1/11/1", O_op_valid, O_op_code, O_late);
    end
    for (int i = 0; i < 4; i++)
      push(op_word(12'h100 + 12'(i), 8'h77, 24'hFF_FFF0));
    n_checks++;
    if (O_level !== 5'd4) begin
      n_fail++;
      $display("FAIL queued_level: got %0d expected 4", O_level);
    end
    I_rst = 1'b1;
    tick();
    n_checks++;
    if (O_level !== 5'd0 || O_late !== 1'b0 || O_overflow !== 1'b0 || O_running !== 1'b0 ||
        O_timer !== 24'd0 || O_op_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: got lvl=%0d late=%b ovf=%b run=%b timer=%0d valid=%b expected all 0",
               O_level, O_late, O_overflow, O_running, O_timer, O_op_valid);
    end
    I_rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (O_op_valid !== 1'b0 || O_level !== 5'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got valid=%b lvl=%0d expected 0/0", O_op_valid, O_level);
    end
  endtask

  initial begin
    tx_if.I_tx_en   = 1'b0;
    tx_if.I_tx_data = '0;
    test_reset();
    test_basic_release();
    test_late();
    test_deadlock_overflow();
    test_back_to_back();
    test_discard_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
